// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack memory port
// and hands them to the consumer over valid/ready. Optional counters: IFETCH_STATS_EN.
module ifetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              ir_rdy,
    output logic [31:0]       ir,
    output logic              ir_vld,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_ack,
`ifdef IFETCH_STATS_EN
    input  logic [31:0]       im_data,
    output logic [31:0]       fetch_cnt,
    output logic [15:0]       flush_cnt
`else
    input  logic [31:0]       im_data
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_VALID = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fa_q, fa_d;
    logic [31:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              ir_vld_q, ir_vld_d;
    logic              im_req_q, im_req_d;
    logic              fetch_inc_s;
    logic              flush_inc_s;

    // Next-state and datapath updates; branch redirect outranks the memory ack.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fa_d        = fa_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        ir_vld_d    = ir_vld_q;
        im_req_d    = im_req_q;
        fetch_inc_s = 1'b0;
        flush_inc_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d  = S_FETCH;
                im_req_d = 1'b1;
                fa_d     = pc_q;
            end
            S_FETCH: begin
                if (br_taken) begin
                    pc_d = br_addr;
                    if (im_ack) begin
                        // Ack closes the old transaction, so re-aim the request at once.
                        fa_d        = br_addr;
                        flush_inc_s = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (im_ack) begin
                    ir_d     = im_data;
                    ir_pc_d  = fa_q;
                    ir_vld_d = 1'b1;
                    pc_d     = fa_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    im_req_d = 1'b0;
                    state_d  = S_VALID;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (im_ack) begin
                    flush_inc_s = 1'b1;
                    state_d     = S_FETCH;
                    if (br_taken) begin
                        pc_d = br_addr;
                        fa_d = br_addr;
                    end else begin
                        fa_d = pc_q;
                    end
                end else if (br_taken) begin
                    pc_d = br_addr;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_VALID: begin
                if (br_taken) begin
                    ir_vld_d = 1'b0;
                    pc_d     = br_addr;
                    fa_d     = br_addr;
                    im_req_d = 1'b1;
                    state_d  = S_FETCH;
                end else if (ir_rdy) begin
                    ir_vld_d    = 1'b0;
                    fa_d        = pc_q;
                    im_req_d    = 1'b1;
                    fetch_inc_s = 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    state_d = S_VALID;
                end
            end
            default: begin
                state_d  = S_IDLE;
                ir_vld_d = 1'b0;
                im_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            fa_q     <= {ADDR_W{1'b0}};
            ir_q     <= 32'h0000_0000;
            ir_pc_q  <= {ADDR_W{1'b0}};
            ir_vld_q <= 1'b0;
            im_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            fa_q     <= fa_d;
            ir_q     <= ir_d;
            ir_pc_q  <= ir_pc_d;
            ir_vld_q <= ir_vld_d;
            im_req_q <= im_req_d;
        end
    end

    assign ir      = ir_q;
    assign ir_vld  = ir_vld_q;
    assign ir_pc   = ir_pc_q;
    assign im_req  = im_req_q;
    assign im_addr = fa_q;

`ifdef IFETCH_STATS_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (fetch_inc_s && (fetch_cnt_q != {32{1'b1}})) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end else begin
            fetch_cnt_d = fetch_cnt_q;
        end
        if (flush_inc_s && (flush_cnt_q != {16{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            fetch_cnt_q <= 32'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a 16-bit-address instance for the main flow
// and a 4-bit-address instance for PC wrap-around.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // main instance
    logic        rst_f = 1'b1, br_taken = 1'b0, ir_rdy = 1'b0, im_ack = 1'b0;
    logic [15:0] br_addr = 16'h0;
    logic [31:0] im_data = 32'h0;
    logic [31:0] ir;
    logic        ir_vld, im_req;
    logic [15:0] ir_pc, im_addr;
    // wrap instance
    logic        rst4 = 1'b1, ir_rdy4 = 1'b0, im_ack4 = 1'b0;
    logic [31:0] im_data4 = 32'h0;
    logic [31:0] ir4;
    logic        ir_vld4, im_req4;
    logic [3:0]  ir_pc4, im_addr4;
`ifdef IFETCH_STATS_EN
    logic [31:0] fetch_cnt, fetch_cnt4;
    logic [15:0] flush_cnt, flush_cnt4;
`endif

    ifetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst_f(rst_f), .br_taken(br_taken), .br_addr(br_addr),
        .ir_rdy(ir_rdy), .ir(ir), .ir_vld(ir_vld), .ir_pc(ir_pc),
        .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack),
`ifdef IFETCH_STATS_EN
        .im_data(im_data), .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`else
        .im_data(im_data)
`endif
    );

    ifetch_unit #(.ADDR_W(4), .RESET_PC(4'h0)) u_dut4 (
        .clk(clk), .rst_f(rst4), .br_taken(1'b0), .br_addr(4'h0),
        .ir_rdy(ir_rdy4), .ir(ir4), .ir_vld(ir_vld4), .ir_pc(ir_pc4),
        .im_req(im_req4), .im_addr(im_addr4), .im_ack(im_ack4),
`ifdef IFETCH_STATS_EN
        .im_data(im_data4), .fetch_cnt(fetch_cnt4), .flush_cnt(flush_cnt4)
`else
        .im_data(im_data4)
`endif
    );

    function automatic logic [31:0] mem(input logic [15:0] a);
        return 32'hA000_0000 + {16'h0000, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [15:0] exp_req_q[$];
    logic [47:0] exp_ir_q[$];   // {ir_pc, ir}
    logic [3:0]  exp_req4_q[$];
    logic [3:0]  exp_pc4_q[$];
    int          n_ir = 0;
    int          cyc = 0;
    int          rise_cyc[$];
    int          lat = 0;

    // memory model: acks after 'lat' cycles of an active request
    initial begin
        int wcnt = 0;
        forever begin
            @(negedge clk);
            if (im_req) begin
                if (wcnt >= lat) begin
                    im_ack = 1'b1; im_data = mem(im_addr); wcnt = 0;
                end else begin
                    im_ack = 1'b0; im_data = 32'hDEAD_BEEF; wcnt++;
                end
            end else begin
                im_ack = 1'b0; im_data = 32'hDEAD_BEEF; wcnt = 0;
            end
            im_ack4  = im_req4;
            im_data4 = mem({12'h000, im_addr4});
        end
    end

    // monitor: new requests and newly presented instructions, just after each edge
    initial begin
        logic prev_req = 1'b0, prev_vld = 1'b0, prev_req4 = 1'b0, prev_vld4 = 1'b0;
        logic [15:0] ea;
        logic [47:0] ei;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (im_req && (!prev_req || im_ack)) begin
                if (exp_req_q.size() == 0) check("unexpected_req", {16'h0, im_addr}, 32'hFFFF_FFFF);
                else begin ea = exp_req_q.pop_front(); check("req_addr", {16'h0, im_addr}, {16'h0, ea}); end
            end
            if (ir_vld && !prev_vld) begin
                n_ir++;
                rise_cyc.push_back(cyc);
                if (exp_ir_q.size() == 0) check("unexpected_ir", ir, 32'hFFFF_FFFF);
                else begin
                    ei = exp_ir_q.pop_front();
                    check("ir", ir, ei[31:0]);
                    check("ir_pc", {16'h0, ir_pc}, {16'h0, ei[47:32]});
                end
            end
            if (im_req4 && (!prev_req4 || im_ack4) && exp_req4_q.size() != 0)
                check("req_addr4", {28'h0, im_addr4}, {28'h0, exp_req4_q.pop_front()});
            if (ir_vld4 && !prev_vld4 && exp_pc4_q.size() != 0)
                check("ir_pc4", {28'h0, ir_pc4}, {28'h0, exp_pc4_q.pop_front()});
            prev_req = im_req; prev_vld = ir_vld; prev_req4 = im_req4; prev_vld4 = ir_vld4;
        end
    end

    task automatic push(input logic [15:0] a, input logic with_ir);
        exp_req_q.push_back(a);
        if (with_ir) exp_ir_q.push_back({a, mem(a)});
    endtask

    task automatic wait_ir(input int n, input int budget);
        int b = budget;
        while (n_ir < n && b > 0) begin @(negedge clk); b--; end
        if (n_ir < n) check("timeout_ir", n_ir, n);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ir"}, ir, 32'h0);
        check({tag, "_ir_vld"}, {31'h0, ir_vld}, 32'h0);
        check({tag, "_ir_pc"}, {16'h0, ir_pc}, 32'h0);
        check({tag, "_im_req"}, {31'h0, im_req}, 32'h0);
        check({tag, "_im_addr"}, {16'h0, im_addr}, 32'h0);
`ifdef IFETCH_STATS_EN
        check({tag, "_fetch_cnt"}, fetch_cnt, 32'h0);
        check({tag, "_flush_cnt"}, {16'h0, flush_cnt}, 32'h0);
`endif
    endtask

    // wrap-around stimulus on the 4-bit instance
    initial begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            exp_req4_q.push_back(4'(i));
            exp_pc4_q.push_back(4'(i));
        end
        ir_rdy4 = 1'b1;
        rst4    = 1'b0;
    end

    // main directed stimulus
    initial begin
        repeat (3) @(negedge clk);
        check_reset("reset");

        // zero-wait streaming 0..3
        for (int a = 0; a < 4; a++) push(16'(a), 1'b1);
        lat = 0; ir_rdy = 1'b1; rst_f = 1'b0;
        wait_ir(4, 40);
        ir_rdy = 1'b0;
        if (rise_cyc.size() >= 4) check("stream_spacing", rise_cyc[3] - rise_cyc[0], 6);

        // addr 4 zero-wait, then addr 5 with three wait cycles
        push(16'h4, 1'b1);
        ir_rdy = 1'b1;
        wait_ir(5, 20);
        ir_rdy = 1'b0;
        lat = 3;
        push(16'h5, 1'b1);
        ir_rdy = 1'b1;
        @(negedge clk);
        ir_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wait_req", {31'h0, im_req}, 32'h1);
            check("wait_addr", {16'h0, im_addr}, 32'h5);
            check("wait_vld", {31'h0, ir_vld}, 32'h0);
            @(negedge clk);
        end
        wait_ir(6, 20);

        // redirect to 0x40 while addr 7 is outstanding
        lat = 0;
        push(16'h6, 1'b1);
        ir_rdy = 1'b1;
        wait_ir(7, 20);
        ir_rdy = 1'b0;
        lat = 2;
        push(16'h7, 1'b0);
        push(16'h40, 1'b1);
        ir_rdy = 1'b1;
        @(negedge clk);
        ir_rdy = 1'b0; br_taken = 1'b1; br_addr = 16'h0040;
        @(negedge clk);
        br_taken = 1'b0;
        check("drain_addr_a", {16'h0, im_addr}, 32'h7);
        @(negedge clk);
        check("drain_addr_b", {16'h0, im_addr}, 32'h7);
        check("drain_req", {31'h0, im_req}, 32'h1);
        wait_ir(8, 20);

        // hold in VALID, then branch with ir_rdy in the same cycle
        for (int i = 0; i < 4; i++) begin
            check("hold_ir", ir, mem(16'h40));
            check("hold_pc", {16'h0, ir_pc}, 32'h40);
            check("hold_vld", {31'h0, ir_vld}, 32'h1);
            @(negedge clk);
        end
        lat = 0;
        push(16'h10, 1'b1);
        br_taken = 1'b1; br_addr = 16'h0010; ir_rdy = 1'b1;
        @(negedge clk);
        br_taken = 1'b0; ir_rdy = 1'b0;
        wait_ir(9, 20);

        // branch coinciding with the ack in FETCH
        push(16'h11, 1'b0);
        push(16'h20, 1'b1);
        ir_rdy = 1'b1;
        @(negedge clk);
        ir_rdy = 1'b0; br_taken = 1'b1; br_addr = 16'h0020;
        @(negedge clk);
        br_taken = 1'b0;
        wait_ir(10, 20);
`ifdef IFETCH_STATS_EN
        check("fetch_cnt", fetch_cnt, 32'd8);
        check("flush_cnt", {16'h0, flush_cnt}, 32'd2);
`endif

        // reset while draining, with the ack in the same cycle
        lat = 1;
        push(16'h21, 1'b0);
        ir_rdy = 1'b1;
        @(negedge clk);
        ir_rdy = 1'b0; br_taken = 1'b1; br_addr = 16'h0030;
        @(negedge clk);
        br_taken = 1'b0; rst_f = 1'b1;
        @(negedge clk);
        check_reset("drain_reset");
        lat = 0;
        push(16'h0, 1'b1);
        rst_f = 1'b0;
        wait_ir(11, 20);

        repeat (4) @(negedge clk);
        check("req_queue_empty", exp_req_q.size(), 0);
        check("ir_queue_empty", exp_ir_q.size(), 0);
        check("wrap_queue_empty", exp_req4_q.size() + exp_pc4_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch unit. It is the producer of the 32-bit instruction word that the SISC datapath consumes as `ir`.
- Owns the program counter and issues word-addressed read requests to instruction memory over a req/ack handshake.
- Presents each returned word to the control/datapath with a valid/ready handshake.
- Accepts branch redirects from the control unit and discards any fetch that was in flight when the redirect arrived.

Parameters:
- ADDR_W, 16, width of the instruction-memory word address and of the PC.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_f  in  1  reset, synchronous, active-high.
- br_taken  in  1  single-cycle branch redirect from ctrl.
- br_addr  in  ADDR_W  branch target word address; valid when br_taken=1.
- ir_rdy  in  1  consumer accepts `ir` this cycle.
- ir  out  32  instruction word.
- ir_vld  out  1  `ir` holds a valid instruction.
- ir_pc  out  ADDR_W  address of the word currently in `ir`.
- im_req  out  1  instruction-memory read request.
- im_addr  out  ADDR_W  read address; stable while im_req=1.
- im_ack  in  1  memory returns data this cycle; single-cycle pulse.
- im_data  in  32  read data, sampled only when im_ack=1.

Behaviour:
- Reset (rst_f=1 at a clock edge), regardless of current state or any outstanding request:
  - state=IDLE, pc=RESET_PC, ir=32'h0, ir_pc=0, ir_vld=0, im_req=0, im_addr=0.
  - A memory ack arriving in the same cycle as reset is ignored.
- Internal registers:
  - pc: next address to fetch.
  - fa: address of the outstanding request; drives im_addr.
- All outputs are registered.
- States: IDLE, FETCH, DRAIN, VALID.
- IDLE: next cycle → FETCH with im_req=1, fa=pc.
- FETCH (im_req=1, im_addr=fa). Priority is br_taken over im_ack:
  - br_taken=1 and im_ack=1: drop im_data; pc=br_addr; stay in FETCH; next request uses fa=br_addr. im_req stays high and the address changes, which is legal because the ack closed the previous transaction.
  - br_taken=1 and im_ack=0: pc=br_addr → DRAIN. im_req and im_addr are held until the ack.
  - im_ack=1 only: ir=im_data; ir_pc=fa; ir_vld=1; pc=fa+1 (mod 2^ADDR_W, so wrap to 0); im_req=0 → VALID.
  - Neither: hold.
- DRAIN (im_req=1, old fa held):
  - im_ack=1: discard data; fa=pc → FETCH.
  - br_taken in DRAIN: pc=br_addr (the latest redirect wins). If it coincides with im_ack, fa=br_addr.
- VALID (ir_vld=1, im_req=0):
  - br_taken=1: ir_vld=0; pc=br_addr → FETCH (fa=br_addr). ir_rdy is ignored in that cycle; the instruction is not consumed.
  - ir_rdy=1: ir_vld=0; fa=pc → FETCH.
  - Otherwise hold. `ir` and `ir_pc` stay stable.
- `ir` keeps its last value when ir_vld=0, so ctrl sees no glitches.
- Latency:
  - Zero-wait memory (ack in the first FETCH cycle) → ir_vld rises 1 cycle after the ack edge.
  - Sustained throughput is 1 instruction per 2 cycles.
  - Branch to first valid target instruction is ≥2 cycles, plus any drain cycles.
- An im_ack arriving while im_req=0 is a protocol error and is ignored.
- The unit never issues a new request while one is outstanding.

Optional Feature:
- Macro: IFETCH_STATS_EN.
- Defined: adds output ports `fetch_cnt[31:0]` and `flush_cnt[15:0]`.
  - Reset value 0 for both.
  - fetch_cnt increments on each VALID→FETCH transition caused by ir_rdy (an accepted instruction).
  - flush_cnt increments on each discarded memory word: the FETCH br_taken+ack case and the DRAIN ack case.
  - Both counters saturate at all-ones.
- Not defined: the ports and their logic are absent. Core behaviour is identical.

Test Plan:
- Reset, then zero-wait memory returning mem[a]=32'hA000_0000+a, with ir_rdy=1 → im_addr 0,1,2,3 in sequence; ir_vld pulses every 2nd cycle; `ir` = A000_0000, A000_0001, …; ir_pc matches.
- Memory ack delayed 3 cycles at addr 5 → im_req and im_addr=5 held for 3 cycles; ir_vld=0 throughout; `ir` then equals mem[5].
- br_taken with br_addr=0x40 while a fetch of addr 7 is pending with ack 2 cycles later → DRAIN holds im_addr=7; mem[7] is never presented; the next request is addr 0x40; first valid `ir`=mem[0x40] with ir_pc=0x40.
- VALID with ir_rdy=0 for 4 cycles, then br_taken with br_addr=0x10 and ir_rdy=1 in the same cycle → `ir` stable during the hold; the next request is 0x10, not pc+1.
- ADDR_W=4, fetch at addr 15 → next request addr 0 (wrap).
- Assert rst_f while in DRAIN with the ack in the same cycle → all outputs take their reset values; the next request is RESET_PC. With IFETCH_STATS_EN: fetch_cnt=0, flush_cnt=0.
